// File: rtl/aes_seq_pkg.sv
// Shared state encoding and plaintext LFSR helper for the AES trace sequencer.
// Polynomial x^128 + x^7 + x^2 + x + 1, Galois form, shifting toward the MSB.
package aes_seq_pkg;

  localparam int LFSR_W = 128;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 128'h87;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic [LFSR_W-1:0] r;
    r = {v[LFSR_W-2:0], 1'b0};
    if (v[LFSR_W-1]) r = r ^ LFSR_TAPS;
    return r;
  endfunction

endpackage

// File: rtl/aes_pt_lfsr.sv
// Plaintext generator: loads a seed (zero forced to one) and steps once per enable.
// q_next exposes the value the register takes at the coming edge.
module aes_pt_lfsr
  import aes_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      q_next = lfsr_step(q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_W'(1);
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/aes_trace_sequencer.sv
// Back-to-back AES encryption sequencer for power/VCD trace capture.
// Optional fixed-vs-random interleave is built when TVLA_FIXED_RANDOM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | run parameters latched, first plaintext prepared
// RUN     | core_en high, waiting for core_valid or timeout
// CAPTURE | ciphertext registered, ct_valid pulse
// GAP     | idle cycles with core_en low between traces
// DONE    | one-cycle done pulse, back to IDLE
module aes_trace_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int KEY_W       = 128,
  parameter int CNT_W       = 16,
  parameter int GAP_CYC     = 15,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              AES_clk,
  input  logic              AES_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_traces,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [DATA_W-1:0] seed_in,
`ifdef TVLA_FIXED_RANDOM_EN
  input  logic [DATA_W-1:0] fixed_pt,
  output logic              fr_sel,
`endif
  output logic              core_en,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_data_out,
  output logic              busy,
  output logic              done,
  output logic              ct_valid,
  output logic [DATA_W-1:0] ct_out,
  output logic [CNT_W-1:0]  trace_idx,
  output logic              timeout_err
);

  localparam int TMR_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RUN_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  seq_state_t        state, state_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic [CNT_W-1:0]  idx_d;
  logic [CNT_W-1:0]  num_q;
  logic              more_q, more_d;
  logic              abort;
  logic              last;
  logic              lfsr_load, lfsr_step_en;
  logic              advance;
  logic              pt_load;
  logic [DATA_W-1:0] lfsr_q, lfsr_nxt;
  logic [DATA_W-1:0] pt_d;

  aes_pt_lfsr u_lfsr (
    .clk    (AES_clk),
    .rst    (AES_rst),
    .load   (lfsr_load),
    .step   (lfsr_step_en),
    .seed   (seed_in),
    .q      (lfsr_q),
    .q_next (lfsr_nxt)
  );

`ifdef TVLA_FIXED_RANDOM_EN
  logic [DATA_W-1:0] fixed_q;

  // Even traces use the fixed block, so the LFSR only moves after odd ones.
  assign advance = trace_idx[0];
  assign pt_d    = idx_d[0] ? lfsr_nxt : fixed_q;
  assign fr_sel  = (state == CAPTURE) && !trace_idx[0];

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      fixed_q <= '0;
    end else if (state == IDLE && start) begin
      fixed_q <= fixed_pt;
    end
  end
`else
  logic unused_lfsr_q;

  assign advance       = 1'b1;
  assign pt_d          = lfsr_nxt;
  assign unused_lfsr_q = ^lfsr_q;
`endif

  assign last = (trace_idx == num_q - CNT_W'(1));

  always_comb begin
    state_d      = state;
    tmr_d        = tmr;
    idx_d        = trace_idx;
    more_d       = more_q;
    abort        = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          idx_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      LOAD: begin
        if (num_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          tmr_d   = RUN_LOAD;
        end
      end
      RUN: begin
        // A valid in the final allowed cycle still counts as a capture.
        if (core_valid) begin
          state_d = CAPTURE;
        end else if (tmr == '0) begin
          state_d = DONE;
          abort   = 1'b1;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      CAPTURE: begin
        lfsr_step_en = advance;
        if (!last) idx_d = trace_idx + CNT_W'(1);
        if (GAP_CYC == 0) begin
          state_d = last ? DONE : RUN;
          tmr_d   = RUN_LOAD;
        end else begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
          more_d  = !last;
        end
      end
      GAP: begin
        if (tmr == '0) begin
          state_d = more_q ? RUN : DONE;
          tmr_d   = RUN_LOAD;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Plaintext only moves on edges where core_en is low beforehand.
  assign pt_load = (state != RUN) && ((state_d == RUN) || (state_d == GAP));

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state       <= IDLE;
      tmr         <= '0;
      trace_idx   <= '0;
      more_q      <= 1'b0;
      num_q       <= '0;
      core_key    <= '0;
      core_data   <= '0;
      ct_out      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_d;
      tmr       <= tmr_d;
      trace_idx <= idx_d;
      more_q    <= more_d;
      if (state == IDLE && start) begin
        num_q       <= num_traces;
        core_key    <= key_in;
        timeout_err <= 1'b0;
      end else if (abort) begin
        timeout_err <= 1'b1;
      end
      if (state == RUN && core_valid) ct_out <= core_data_out;
      if (pt_load) core_data <= pt_d;
    end
  end

  assign core_en  = (state == RUN);
  assign ct_valid = (state == CAPTURE);
  assign done     = (state == DONE);
  assign busy     = (state == LOAD) || (state == RUN) || (state == CAPTURE) || (state == GAP);

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: programmable-latency core stub, plaintext/ciphertext
// scoreboard, table of runs plus reset sequences.
module tb_aes_trace_sequencer;

  localparam int GAP = 15;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         AES_rst;
  logic         start;
  logic [15:0]  num_traces;
  logic [127:0] key_in, seed_in;
  logic         core_en, core_valid, busy, done, ct_valid, timeout_err;
  logic [127:0] core_data, core_key, core_data_out, ct_out;
  logic [15:0]  trace_idx;
`ifdef TVLA_FIXED_RANDOM_EN
  logic [127:0] fixed_pt;
  logic         fr_sel;
`endif

  aes_trace_sequencer #(
    .DATA_W(128), .KEY_W(128), .CNT_W(16), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .AES_clk       (clk),
    .AES_rst       (AES_rst),
    .start         (start),
    .num_traces    (num_traces),
    .key_in        (key_in),
    .seed_in       (seed_in),
`ifdef TVLA_FIXED_RANDOM_EN
    .fixed_pt      (fixed_pt),
    .fr_sel        (fr_sel),
`endif
    .core_en       (core_en),
    .core_data     (core_data),
    .core_key      (core_key),
    .core_valid    (core_valid),
    .core_data_out (core_data_out),
    .busy          (busy),
    .done          (done),
    .ct_valid      (ct_valid),
    .ct_out        (ct_out),
    .trace_idx     (trace_idx),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] m_step(input logic [127:0] v);
    logic [127:0] r;
    r = v << 1;
    r[0] = v[127];
    r[1] = r[1] ^ v[127];
    r[2] = r[2] ^ v[127];
    r[7] = r[7] ^ v[127];
    return r;
  endfunction

  function automatic logic [127:0] stub_ct(input logic [127:0] p, input logic [127:0] k);
    return {p[95:0], p[127:96]} ^ k ^ 128'hC3C3_5A5A_0F0F_9696_C3C3_5A5A_0F0F_9696;
  endfunction

  // Core stub: valid after stub_lat RUN cycles (0 = first cycle); spur forces valid anywhere.
  int stub_lat = 0;
  bit stub_never = 1'b0;
  bit spur = 1'b0;
  int stub_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!core_en || AES_rst) stub_cnt <= 0;
    else stub_cnt <= stub_cnt + 1;
  end

  assign core_valid    = (core_en && !stub_never && stub_cnt == stub_lat) || spur;
  assign core_data_out = stub_ct(core_data, core_key);

  // Reference model and scoreboard
  typedef struct packed {
    logic [15:0]  idx;
    logic [127:0] ct;
  } exp_t;

  exp_t         sb[$];
  int           m_idx = 0;
  logic [127:0] m_lfsr = 128'h1;
  logic [127:0] m_key = '0;
  logic [127:0] m_fixed = '0;
  bit           m_first = 1'b1;
  logic [127:0] hold_pt = '0;
  bit           en_prev = 1'b0;
  int           ct_cnt = 0, done_cnt = 0, rise_cnt = 0;
  int           last_ct_cyc = 0, done_cyc = 0, last_rise_cyc = 0, start_cyc = 0;

  function automatic logic [127:0] exp_pt();
`ifdef TVLA_FIXED_RANDOM_EN
    return (m_idx % 2 == 0) ? m_fixed : m_lfsr;
`else
    return m_lfsr;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (core_en && !en_prev) begin
      chk("core_data_trace", core_data, exp_pt());
      chk("core_key", core_key, m_key);
      if (!m_first) chk("gap_len", cyc - last_ct_cyc, GAP + 1);
      m_first = 1'b0;
      sb.push_back('{idx: 16'(m_idx), ct: stub_ct(exp_pt(), m_key)});
      hold_pt = core_data;
      last_rise_cyc = cyc;
      rise_cnt++;
    end else if (core_en) begin
      chk("core_data_stable", core_data, hold_pt);
    end
    if (ct_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ct_unexpected: got ct_valid with ct %h, expected no capture", ct_out);
      end else begin
        e = sb.pop_front();
        chk("ct_out", ct_out, e.ct);
        chk("trace_idx_ct", trace_idx, e.idx);
      end
`ifdef TVLA_FIXED_RANDOM_EN
      chk("fr_sel", fr_sel, (m_idx % 2 == 0) ? 1 : 0);
      if (m_idx % 2 == 1) m_lfsr = m_step(m_lfsr);
`else
      m_lfsr = m_step(m_lfsr);
`endif
      m_idx++;
      ct_cnt++;
      last_ct_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    en_prev = core_en;
  end

  typedef struct {
    int           num;
    logic [127:0] seed;
    logic [127:0] key;
    int           lat;
    bit           never;
    int           restart_at;
    int           spur_at;
    int           exp_ct;
    bit           exp_to;
  } vec_t;

  localparam logic [127:0] KEY_A = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] KEY_B = 128'h00112233_44556677_8899aabb_ccddeeff;

  vec_t vecs[8];

  task automatic set_model(input logic [127:0] seed, input logic [127:0] key);
    m_idx   = 0;
    m_lfsr  = (seed == '0) ? 128'h1 : seed;
    m_key   = key;
    m_fixed = ~seed;
    m_first = 1'b1;
  endtask

  task automatic pulse_start(input int num, input logic [127:0] seed, input logic [127:0] key);
    @(posedge clk); #1;
    num_traces = 16'(num);
    seed_in    = seed;
    key_in     = key;
`ifdef TVLA_FIXED_RANDOM_EN
    fixed_pt   = ~seed;
`endif
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int ct0, done0, rise0, exp_idx;
    bit seen;
    stub_lat   = v.lat;
    stub_never = v.never;
    set_model(v.seed, v.key);
    ct0   = ct_cnt;
    done0 = done_cnt;
    rise0 = rise_cnt;
    pulse_start(v.num, v.seed, v.key);
    chk("busy_on_start", busy, 1);
    chk("timeout_clr_on_start", timeout_err, 0);
    seen = 1'b0;
    for (int i = 2; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      start = (v.restart_at == i);
      if (v.restart_at == i) num_traces = 16'd7;
      spur = (v.spur_at == i);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    spur  = 1'b0;
    @(posedge clk); #1;
    exp_idx = v.exp_to ? v.exp_ct : ((v.num > 0) ? v.num - 1 : 0);
    chk("done_seen", seen, 1);
    chk("done_width", done, 0);
    chk("done_count", done_cnt - done0, 1);
    chk("ct_count", ct_cnt - ct0, v.exp_ct);
    chk("timeout_err", timeout_err, v.exp_to);
    chk("busy_after", busy, 0);
    chk("trace_idx_final", trace_idx, exp_idx);
    if (v.exp_to) begin
      chk("abort_latency", done_cyc - last_rise_cyc, TO);
    end else if (v.num == 0) begin
      chk("zero_done_latency", done_cyc - start_cyc, 2);
      chk("zero_no_core_en", rise_cnt - rise0, 0);
    end else begin
      chk("done_after_gap", done_cyc - last_ct_cyc, GAP + 1);
      chk("sb_empty", sb.size(), 0);
    end
    sb.delete();
  endtask

  initial begin
    int ct0, done0;
    bit hit;
    vecs[0] = '{3, 128'h1, KEY_A, 11, 1'b0, 0, 0, 3, 1'b0};
    vecs[1] = '{1, 128'h00000078_00000000_00000000_00000000, KEY_A, 20, 1'b0, 0, 0, 1, 1'b0};
    vecs[2] = '{4, 128'h0, KEY_B, 0, 1'b0, 0, 0, 4, 1'b0};
    vecs[3] = '{2, 128'h12345678_9abcdef0_0fedcba9_87654321, KEY_B, 63, 1'b0, 0, 0, 2, 1'b0};
    vecs[4] = '{1, 128'hdead_beef, KEY_A, 0, 1'b1, 0, 0, 0, 1'b1};
    vecs[5] = '{0, 128'h5, KEY_B, 3, 1'b0, 0, 0, 0, 1'b0};
    vecs[6] = '{2, 128'h80000000_00000000_00000000_00000001, KEY_A, 5, 1'b0, 5, 12, 2, 1'b0};
    vecs[7] = '{5, 128'h80000000_00000000_00000000_00000000, KEY_B, 3, 1'b0, 0, 0, 5, 1'b0};

    AES_rst    = 1'b1;
    start      = 1'b0;
    num_traces = '0;
    key_in     = '0;
    seed_in    = '0;
`ifdef TVLA_FIXED_RANDOM_EN
    fixed_pt   = '0;
`endif
    repeat (3) @(posedge clk);
    #1 AES_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_core_en", core_en, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_out", ct_out, 0);
    chk("rst_trace_idx", trace_idx, 0);
    chk("rst_timeout_err", timeout_err, 0);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid_ignored", ct_valid, 0);
    chk("idle_no_done", done_cnt, 0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Reset in the middle of trace 1's RUN phase
    stub_lat   = 10;
    stub_never = 1'b0;
    set_model(128'h77, KEY_B);
    pulse_start(3, 128'h77, KEY_B);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #1;
      if (core_en && m_idx == 1) hit = 1'b1;
    end
    chk("reach_trace1_run", hit, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_core_en", core_en, 1);
    ct0   = ct_cnt;
    done0 = done_cnt;
    AES_rst = 1'b1;
    @(posedge clk); #1;
    AES_rst = 1'b0;
    chk("midrst_core_en", core_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_trace_idx", trace_idx, 0);
    chk("midrst_core_data", core_data, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - done0, 0);
    chk("midrst_no_ct", ct_cnt - ct0, 0);
    chk("midrst_idle", core_en, 0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
